stim_player: RTL and testbench
==============================

Name: stim_player

Overview:
- Synthesizable vector replay engine that drives the FSM under test with {rst, in} stimulus vectors from on-chip memory.
- Extends the fixed one-vector-per-cycle file playback with:
  - a loadable memory
  - per-vector repeat counts
  - a programmable sequence length
  - loop mode
  - start/stop control
  - an output signature over the DUT response
- Sits between the host load interface and the DUT, inside the same single clock domain.

Parameters:
IN_LEN, 7, width of DUT data input
OUT_LEN, 19, width of DUT output (signature width)
ADDR_W, 10, vector memory address width; depth = 2**ADDR_W
RPT_W, 8, repeat-count field width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
wr_en  in  1  memory write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  1+IN_LEN+RPT_W  {v_rst, v_in, repeat}
start  in  1  begin playback at address 0
stop  in  1  abort playback
loop_en  in  1  wrap to address 0 after last_addr
last_addr  in  ADDR_W  index of final vector, latched at start
dut_out  in  OUT_LEN  DUT response
dut_rst  out  1  reset bit to DUT
dut_in  out  IN_LEN  data to DUT
busy  out  1  FETCH or PLAY
done  out  1  high in DONE state
wr_err  out  1  one-cycle pulse: write attempted while busy
vec_idx  out  ADDR_W  address of vector currently driven
loop_cnt  out  16  completed passes, saturating at 16'hFFFF
sig  out  OUT_LEN  response signature

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - Outputs: dut_rst=1, dut_in=0, busy=0, done=0, wr_err=0, vec_idx=0, loop_cnt=0, sig=0.
  - Memory contents are not cleared. Reset mid-play aborts immediately.
- Memory:
  - Writes are synchronous and accepted only when busy=0.
  - wr_en while busy=1: write dropped; wr_err pulses for 1 cycle.
  - Read latency is 1 cycle.
- States: IDLE, FETCH, PLAY, DONE.
- IDLE:
  - Outputs held at dut_rst=1, dut_in=0.
  - start=1: latch last_addr and loop_en, clear sig and loop_cnt, issue read of addr 0, go to FETCH.
  - stop is ignored in IDLE.
- FETCH (1 cycle): go to PLAY.
  - Vector 0 appears on dut_rst/dut_in in the first PLAY cycle, i.e. 2 cycles after start is sampled.
- PLAY:
  - Entry k is driven for repeat_k+1 consecutive cycles (repeat=0 gives 1 cycle; repeat=2**RPT_W-1 gives 2**RPT_W cycles).
  - Entry k+1 follows with no gap and no bubble. The next entry must be prefetched on the last repeat cycle.
  - vec_idx = k while entry k is driven.
  - After the final cycle of last_addr:
    - loop_en latched=1: wrap to entry 0 with no gap, loop_cnt+1.
    - Otherwise: loop_cnt+1, go to DONE.
  - stop=1 in FETCH or PLAY: go to DONE next cycle. The vector driven in the stop cycle is the last one applied.
  - start is ignored while busy.
- DONE:
  - done=1; dut_rst=1, dut_in=0.
  - sig and loop_cnt are held.
  - start=1 restarts exactly as from IDLE (goes to FETCH, done deasserts next cycle).
- Signature:
  - Updated every PLAY cycle: sig <= {sig[OUT_LEN-2:0], sig[OUT_LEN-1]} ^ dut_out.
  - Not updated in any other state.
- last_addr=0 plays a single entry. Reaching address 2**ADDR_W-1 with loop_en latched wraps to 0.
- busy=1 exactly in FETCH and PLAY.

Test Plan:
- Load 3 entries (in=7'h01,02,03; repeat=0; v_rst=0), last_addr=2, start -> dut_in is 01,02,03 on cycles 2,3,4 after start, DONE on cycle 5, loop_cnt=1.
- Entry 0 repeat=3 (in=7'h55), entry 1 repeat=0 (in=7'h2A) -> 55 driven for 4 cycles, then 2A for 1 cycle, then done; no gap between them.
- loop_en=1, last_addr=1 (in=7'h11, 7'h22), run 10 PLAY cycles -> sequence 11,22 repeated 5 times, loop_cnt=5; stop -> done=1, dut_rst=1 next cycle.
- wr_en mid-play to addr 0 with 7'h7F -> wr_err pulses once; memory unchanged; next pass still drives the original value.
- dut_out tied to 19'h00001 for 3 PLAY cycles starting from sig=0 -> sig=19'h00001, then 19'h00003, then 19'h00007.
- rst=0 for 1 cycle mid-PLAY -> next cycle IDLE, outputs at reset values; a subsequent start replays the retained memory correctly.

Source files
------------

// File: rtl/stim_player.sv
// Replays {rst, in} vectors from a loadable memory into the FSM under test and folds its response into a signature.
// Latency: first vector reaches dut_rst/dut_in two cycles after start is sampled; then one entry per repeat_k+1 cycles, gap-free.
// Backpressure: none; host writes are dropped (wr_err pulse) while busy, and stop aborts playback on the next cycle.
module stim_player #(
    parameter int IN_LEN  = 7,
    parameter int OUT_LEN = 19,
    parameter int ADDR_W  = 10,
    parameter int RPT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [IN_LEN+RPT_W:0]     wr_data,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [ADDR_W-1:0]         last_addr,
    input  logic [OUT_LEN-1:0]        dut_out,
    output logic                      dut_rst,
    output logic [IN_LEN-1:0]         dut_in,
    output logic                      busy,
    output logic                      done,
    output logic                      wr_err,
    output logic [ADDR_W-1:0]         vec_idx,
    output logic [15:0]               loop_cnt,
    output logic [OUT_LEN-1:0]        sig
);
    localparam int W = 1 + IN_LEN + RPT_W;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       mem [2**ADDR_W];
    logic [W-1:0]       rd_dat;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_en;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  next_addr;
    logic [ADDR_W-1:0]  last_q;
    logic               loop_q;
    logic [RPT_W-1:0]   rpt_cnt;
    logic               last_rpt;
    logic               pass_end;

    // rd_dat always holds the entry being driven in PLAY; it is reloaded on the last repeat cycle.
    assign last_rpt  = (rpt_cnt == rd_dat[RPT_W-1:0]);
    assign pass_end  = (state_q == PLAY) && last_rpt && (cur_addr == last_q);
    assign next_addr = pass_end ? '0 : cur_addr + ADDR_W'(1);

    assign busy    = (state_q == FETCH) || (state_q == PLAY);
    assign done    = (state_q == DONE);
    assign dut_rst = (state_q == PLAY) ? rd_dat[W-1] : 1'b1;
    assign dut_in  = (state_q == PLAY) ? rd_dat[W-2:RPT_W] : '0;
    assign vec_idx = cur_addr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = FETCH;
                    rd_en   = 1'b1;
                end
            end
            FETCH: begin
                state_d = stop ? DONE : PLAY;
            end
            PLAY: begin
                if (stop || (pass_end && !loop_q)) begin
                    state_d = DONE;
                end else if (last_rpt) begin
                    rd_en   = 1'b1;
                    rd_addr = next_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory has no reset so that contents survive a reset of the player.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_addr <= '0;
            last_q   <= '0;
            loop_q   <= 1'b0;
            rpt_cnt  <= '0;
            loop_cnt <= '0;
            sig      <= '0;
            wr_err   <= 1'b0;
        end else begin
            wr_err <= wr_en && busy;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        last_q   <= last_addr;
                        loop_q   <= loop_en;
                        sig      <= '0;
                        loop_cnt <= '0;
                        cur_addr <= '0;
                        rpt_cnt  <= '0;
                    end
                end
                PLAY: begin
                    sig <= {sig[OUT_LEN-2:0], sig[OUT_LEN-1]} ^ dut_out;
                    if (pass_end && (loop_cnt != 16'hFFFF)) begin
                        loop_cnt <= loop_cnt + 16'd1;
                    end
                    if (last_rpt) begin
                        rpt_cnt <= '0;
                        // vec_idx keeps the final applied entry when playback ends here.
                        if (!stop && (loop_q || !pass_end)) begin
                            cur_addr <= next_addr;
                        end
                    end else begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stim_player.sv
// Randomized bench for stim_player: an expected play list is expanded from the memory image and compared cycle by cycle.
module tb_stim_player;
    localparam int IN_LEN  = 7;
    localparam int OUT_LEN = 19;
    localparam int ADDR_W  = 10;
    localparam int RPT_W   = 8;
    localparam int W       = 1 + IN_LEN + RPT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [W-1:0]        wr_data;
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [ADDR_W-1:0]   last_addr;
    logic [OUT_LEN-1:0]  dut_out;
    logic                dut_rst;
    logic [IN_LEN-1:0]   dut_in;
    logic                busy;
    logic                done;
    logic                wr_err;
    logic [ADDR_W-1:0]   vec_idx;
    logic [15:0]         loop_cnt;
    logic [OUT_LEN-1:0]  sig;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] model_mem [2**ADDR_W];

    stim_player #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .ADDR_W(ADDR_W), .RPT_W(RPT_W)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_en(loop_en), .last_addr(last_addr),
        .dut_out(dut_out), .dut_rst(dut_rst), .dut_in(dut_in), .busy(busy),
        .done(done), .wr_err(wr_err), .vec_idx(vec_idx), .loop_cnt(loop_cnt), .sig(sig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_wr_err"},   32'(wr_err),   32'd0);
        chk({tag, "_dut_rst"},  32'(dut_rst),  32'd1);
        chk({tag, "_dut_in"},   32'(dut_in),   32'd0);
        chk({tag, "_vec_idx"},  32'(vec_idx),  32'd0);
        chk({tag, "_loop_cnt"}, 32'(loop_cnt), 32'd0);
        chk({tag, "_sig"},      32'(sig),      32'd0);
    endtask

    task automatic load(input int a, input bit vr, input int vin, input int rpt);
        logic [W-1:0] word;
        word = {vr, IN_LEN'(vin), RPT_W'(rpt)};
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = word;
        model_mem[a] = word;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    // One start..end session; stop/write/reset are injected in the given play cycle (-1 = never).
    task automatic run_session(input int last, input bit lp, input int stop_at,
                               input int wr_at, input int rst_at, input bit fixed_dout);
        int pq[$];
        bit pe[$];
        int n;
        int passes;
        int nrep;
        logic [OUT_LEN-1:0] sm;
        logic [OUT_LEN-1:0] dout;
        logic [W-1:0] e;
        do begin
            for (int k = 0; k <= last; k++) begin
                e = model_mem[k];
                nrep = int'(e[RPT_W-1:0]) + 1;
                for (int r = 0; r < nrep; r++) begin
                    pq.push_back(k);
                    pe.push_back(k == last && r == nrep - 1);
                end
            end
        end while (lp && pq.size() <= stop_at);
        n = pq.size();
        if (stop_at >= 0 && stop_at < n) n = stop_at + 1;
        if (rst_at >= 0 && rst_at < n) n = rst_at + 1;

        @(negedge clk);
        start     = 1'b1;
        last_addr = ADDR_W'(last);
        loop_en   = lp;
        @(negedge clk);
        start     = 1'b0;
        last_addr = ADDR_W'($urandom);
        loop_en   = ~lp;
        chk("fetch_busy", 32'(busy), 32'd1);
        chk("fetch_done", 32'(done), 32'd0);
        chk("fetch_sig", 32'(sig), 32'd0);
        chk("fetch_loop_cnt", 32'(loop_cnt), 32'd0);

        sm = '0;
        passes = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = model_mem[pq[i]];
            chk("play_dut_in", 32'(dut_in), 32'(e[W-2:RPT_W]));
            chk("play_dut_rst", 32'(dut_rst), 32'(e[W-1]));
            chk("play_vec_idx", 32'(vec_idx), 32'(pq[i]));
            chk("play_busy", 32'(busy), 32'd1);
            chk("play_loop_cnt", 32'(loop_cnt), 32'(passes));
            chk("play_sig", 32'(sig), 32'(sm));
            chk("play_wr_err", 32'(wr_err), 32'(i > 0 && i - 1 == wr_at));
            dout    = fixed_dout ? OUT_LEN'(1) : OUT_LEN'($urandom);
            dut_out = dout;
            stop    = (i == stop_at);
            wr_en   = (i == wr_at);
            wr_addr = '0;
            wr_data = {1'b0, 7'h7F, 8'h00};
            rst     = (i == rst_at) ? 1'b0 : 1'b1;
            sm = ((sm << 1) | (sm >> (OUT_LEN - 1))) ^ dout;
            if (pe[i]) passes++;
        end

        @(negedge clk);
        stop  = 1'b0;
        wr_en = 1'b0;
        rst   = 1'b1;
        if (rst_at >= 0 && rst_at < n) begin
            chk_reset_outputs("midplay_rst");
        end else begin
            chk("end_done", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
            chk("end_dut_rst", 32'(dut_rst), 32'd1);
            chk("end_dut_in", 32'(dut_in), 32'd0);
            chk("end_loop_cnt", 32'(loop_cnt), 32'(passes));
            chk("end_sig", 32'(sig), 32'(sm));
            chk("end_wr_err", 32'(wr_err), 32'(wr_at == n - 1));
            dut_out = OUT_LEN'($urandom);
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_sig", 32'(sig), 32'(sm));
            chk("hold_loop_cnt", 32'(loop_cnt), 32'(passes));
        end
    endtask

    initial begin
        int last;
        int stop_at;
        int wr_at;
        bit lp;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        stop = 1'b0; loop_en = 1'b0; last_addr = '0; dut_out = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Three single-cycle entries; dut_out held at 1 walks sig through 1, 3, 7.
        load(0, 1'b0, 7'h01, 0);
        load(1, 1'b0, 7'h02, 0);
        load(2, 1'b0, 7'h03, 0);
        run_session(2, 1'b0, -1, -1, -1, 1'b1);

        load(0, 1'b0, 7'h55, 3);
        load(1, 1'b0, 7'h2A, 0);
        run_session(1, 1'b0, -1, -1, -1, 1'b0);

        load(0, 1'b0, 7'h11, 0);
        load(1, 1'b0, 7'h22, 0);
        run_session(1, 1'b1, 10, -1, -1, 1'b0);
        run_session(1, 1'b1, 10, 2, -1, 1'b0);
        run_session(1, 1'b1, 20, -1, 5, 1'b0);
        run_session(1, 1'b0, -1, -1, -1, 1'b0);

        // Maximum repeat on a single-entry sequence.
        load(0, 1'b1, 7'h3C, 255);
        run_session(0, 1'b0, -1, -1, -1, 1'b0);

        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < 8; a++) begin
                load(a, 1'($urandom), int'($urandom_range(0, 127)), int'($urandom_range(0, 3)));
            end
            last = int'($urandom_range(0, 7));
            lp = 1'($urandom);
            if (lp) stop_at = int'($urandom_range(0, 40));
            else stop_at = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 10)) : -1;
            wr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_session(last, lp, stop_at, wr_at, -1, 1'b0);
        end

        // Full-depth sequence wraps from the top address back to 0.
        for (int a = 0; a < 2**ADDR_W; a++) begin
            load(a, 1'((a >> 7) & 1), a & 127, 0);
        end
        run_session(2**ADDR_W - 1, 1'b1, 2**ADDR_W + 1, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
